// File: rtl/wb_pkg.sv
// Shared Wishbone B4 definitions for the round-robin bus arbiter slice.
package wb_pkg;

  localparam int WB_AW   = 32;
  localparam int WB_DW   = 32;
  localparam int WB_SW   = 4;
  localparam int WB_CTIW = 3;
  localparam int WB_BTEW = 2;

  localparam logic [2:0] CLASSIC = 3'b000;
  localparam logic [2:0] CONST   = 3'b001;
  localparam logic [2:0] INCR    = 3'b010;
  localparam logic [2:0] EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_t;

  // Index width that stays legal for a single master.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundles the N-master and single-slave Wishbone signals seen by the arbiter.
interface wb_arbiter_if #(
  parameter int num_masters = 2
);
  import wb_pkg::*;

  logic [num_masters*WB_AW-1:0]   wbm_adr_i;
  logic [num_masters*WB_DW-1:0]   wbm_dat_i;
  logic [num_masters*WB_SW-1:0]   wbm_sel_i;
  logic [num_masters-1:0]         wbm_we_i;
  logic [num_masters-1:0]         wbm_cyc_i;
  logic [num_masters-1:0]         wbm_stb_i;
  logic [num_masters*WB_CTIW-1:0] wbm_cti_i;
  logic [num_masters*WB_BTEW-1:0] wbm_bte_i;
  logic [num_masters*WB_DW-1:0]   wbm_dat_o;
  logic [num_masters-1:0]         wbm_ack_o;
  logic [num_masters-1:0]         wbm_err_o;
  logic [num_masters-1:0]         wbm_rty_o;

  logic [WB_AW-1:0]   wbs_adr_o;
  logic [WB_DW-1:0]   wbs_dat_o;
  logic [WB_SW-1:0]   wbs_sel_o;
  logic               wbs_we_o;
  logic               wbs_cyc_o;
  logic               wbs_stb_o;
  logic [WB_CTIW-1:0] wbs_cti_o;
  logic [WB_BTEW-1:0] wbs_bte_o;
  logic [WB_DW-1:0]   wbs_dat_i;
  logic               wbs_ack_i;
  logic               wbs_err_i;
  logic               wbs_rty_i;

  // Arbiter view: it masters the shared downstream bus.
  modport master (
    input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
  );

  modport slave (
    output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o,
    output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
  );

endinterface

// File: rtl/wb_rr_picker.sv
// Combinational round-robin picker: first requester after the last winner, with wrap.
module wb_rr_picker
  import wb_pkg::*;
#(
  parameter int num_masters = 2,
  parameter int IW          = idx_width(num_masters)
) (
  input  logic [num_masters-1:0] req,
  input  logic [IW-1:0]          last,
  output logic [num_masters-1:0] gnt,
  output logic [IW-1:0]          idx
);

  logic found_s;
  int   k_s;

  // Scan (last+1) .. (last+N) modulo N and keep the first hit.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    found_s = 1'b0;
    k_s     = 0;
    for (int i = 1; i <= num_masters; i++) begin
      k_s = (int'(last) + i) % num_masters;
      if (!found_s && req[k_s]) begin
        found_s  = 1'b1;
        gnt[k_s] = 1'b1;
        idx      = IW'(k_s);
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// N-master to 1-slave Wishbone B4 classic arbiter with round-robin grant held per cycle
// and an optional watchdog that ends hung transfers with err.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int num_masters = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  wb_arbiter_if.master           bus,
  output logic [num_masters-1:0] grant_o
);

  localparam int IW = idx_width(num_masters);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IW-1:0] LAST_RST = IW'(num_masters - 1);

  arb_state_t             state_r, state_s;
  logic [num_masters-1:0] gnt_r, gnt_s, pick_gnt_s;
  logic [IW-1:0]          gidx_r, gidx_s, last_r, last_s, pick_idx_s;
  logic [CW-1:0]          cnt_r, cnt_s;
  logic                   cyc_g_s, stb_g_s, term_s, fire_s;

  wb_rr_picker #(
    .num_masters(num_masters),
    .IW         (IW)
  ) u_picker (
    .req (bus.wbm_cyc_i),
    .last(last_r),
    .gnt (pick_gnt_s),
    .idx (pick_idx_s)
  );

  // Granted-master handshake and watchdog fire; raw stb avoids a loop through the mask.
  always_comb begin
    cyc_g_s = bus.wbm_cyc_i[gidx_r];
    stb_g_s = bus.wbm_stb_i[gidx_r];
    term_s  = bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i;
    fire_s  = (TIMEOUT > 0) && (state_r == GRANTED) && cyc_g_s && stb_g_s
              && !term_s && (cnt_r == CNT_LAST);
  end

  // Next-state: arbitrate in IDLE, hold until the owner drops cyc, run the watchdog.
  always_comb begin
    state_s = state_r;
    gnt_s   = gnt_r;
    gidx_s  = gidx_r;
    last_s  = last_r;
    cnt_s   = '0;
    case (state_r)
      IDLE: begin
        if (|bus.wbm_cyc_i) begin
          state_s = GRANTED;
          gnt_s   = pick_gnt_s;
          gidx_s  = pick_idx_s;
          last_s  = pick_idx_s;
        end else begin
          state_s = IDLE;
        end
      end
      GRANTED: begin
        if (!cyc_g_s) begin
          state_s = IDLE;
          gnt_s   = '0;
        end else if ((TIMEOUT > 0) && stb_g_s && !term_s && !fire_s) begin
          cnt_s = cnt_r + 1'b1;
        end else begin
          cnt_s = '0;
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = '0;
      end
    endcase
  end

  // State, grant, round-robin pointer and watchdog counter.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_r <= IDLE;
      gnt_r   <= '0;
      gidx_r  <= '0;
      last_r  <= LAST_RST;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      gnt_r   <= gnt_s;
      gidx_r  <= gidx_s;
      last_r  <= last_s;
      cnt_r   <= cnt_s;
    end
  end

  // Request mux to the slave and response routing back to the owner only.
  always_comb begin
    bus.wbs_adr_o = '0;
    bus.wbs_dat_o = '0;
    bus.wbs_sel_o = '0;
    bus.wbs_we_o  = 1'b0;
    bus.wbs_cyc_o = 1'b0;
    bus.wbs_stb_o = 1'b0;
    bus.wbs_cti_o = '0;
    bus.wbs_bte_o = '0;
    bus.wbm_ack_o = '0;
    bus.wbm_err_o = '0;
    bus.wbm_rty_o = '0;
    bus.wbm_dat_o = {num_masters{bus.wbs_dat_i}};
    if (state_r == GRANTED) begin
      bus.wbs_adr_o = bus.wbm_adr_i[gidx_r*WB_AW +: WB_AW];
      bus.wbs_dat_o = bus.wbm_dat_i[gidx_r*WB_DW +: WB_DW];
      bus.wbs_sel_o = bus.wbm_sel_i[gidx_r*WB_SW +: WB_SW];
      bus.wbs_we_o  = bus.wbm_we_i[gidx_r];
      bus.wbs_cyc_o = cyc_g_s;
      bus.wbs_stb_o = stb_g_s & ~fire_s;
      bus.wbs_cti_o = bus.wbm_cti_i[gidx_r*WB_CTIW +: WB_CTIW];
      bus.wbs_bte_o = bus.wbm_bte_i[gidx_r*WB_BTEW +: WB_BTEW];
      bus.wbm_ack_o[gidx_r] = bus.wbs_ack_i;
      bus.wbm_err_o[gidx_r] = bus.wbs_err_i | fire_s;
      bus.wbm_rty_o[gidx_r] = bus.wbs_rty_i;
    end else begin
      bus.wbs_cyc_o = 1'b0;
      bus.wbs_stb_o = 1'b0;
    end
  end

  assign grant_o = gnt_r;

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- N-master to 1-slave Wishbone B4 classic arbiter; the reverse direction of the address-decoding slave mux.
- Sits in front of the shared interconnect so that instruction fetch and load/store (and later DMA) masters can share one Wishbone bus.
- Uses round-robin arbitration, holds the grant for the whole cycle (cyc), and has an optional bus-timeout watchdog that terminates hung transfers with err.

Parameters:
- num_masters, 2, number of masters (2..8).
- TIMEOUT, 255, cycles allowed without ack/err/rty before a forced err; 0 disables the watchdog.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, asynchronous, active-low.
- wbm_adr_i  in  num_masters*32  master addresses, master k at bits [k*32 +: 32].
- wbm_dat_i  in  num_masters*32  master write data.
- wbm_sel_i  in  num_masters*4  byte selects.
- wbm_we_i  in  num_masters  write enables.
- wbm_cyc_i  in  num_masters  cycle requests.
- wbm_stb_i  in  num_masters  strobes.
- wbm_cti_i  in  num_masters*3  cycle type identifiers.
- wbm_bte_i  in  num_masters*2  burst type extensions.
- wbm_dat_o  out  num_masters*32  read data (slave data broadcast to all masters).
- wbm_ack_o  out  num_masters  ack, granted master only.
- wbm_err_o  out  num_masters  err, granted master only.
- wbm_rty_o  out  num_masters  rty, granted master only.
- wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o  out  32,32,4,1,1,1,3,2  slave-side request.
- wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i  in  32,1,1,1  slave-side response.
- grant_o  out  num_masters  one-hot current grant (debug/perf counters).

Behaviour:
- Reset (asserted low, asynchronous):
  - grant=0, state=IDLE, last pointer=num_masters-1 (so master 0 has first priority), timeout counter=0.
  - All of wbs_cyc_o, wbs_stb_o, wbs_we_o, wbm_ack_o, wbm_err_o, wbm_rty_o and grant_o = 0.
  - Reset asserted mid-transfer drops wbs_cyc_o immediately. No response is delivered to the master.
- FSM IDLE:
  - wbs_cyc_o=0 and wbs_stb_o=0.
  - If any wbm_cyc_i is high, pick the first requester scanning from (last+1) mod N upward with wrap.
  - Register the one-hot grant, set last to that index, and go to GRANTED.
  - Arbitration latency is 1 cycle: wbs_cyc_o rises the cycle after the request is seen.
- FSM GRANTED:
  - All wbs_* request outputs mux combinationally from the granted master.
  - wbs_cyc_o = wbm_cyc_i[g].
  - wbs_stb_o = wbm_stb_i[g] & ~timeout_fire.
  - Slave ack/err/rty route combinationally to master g only; other masters see 0.
- Release:
  - When wbm_cyc_i[g] goes low: grant clears on the next edge and the state returns to IDLE.
  - At least one IDLE cycle always separates two grants, including a re-grant to the same master.
  - Requests from other masters are ignored while granted (no preemption).
  - If master g drops cyc while its stb is outstanding, wbs_cyc_o falls in the same cycle. The slave must tolerate an aborted cycle.
- Timeout (TIMEOUT>0):
  - Counter increments each cycle with wbs_cyc_o & wbs_stb_o & ~(ack|err|rty).
  - Counter clears on any termination, on stb low, or on leaving GRANTED.
  - When the counter equals TIMEOUT-1 and no termination is present, timeout_fire is high for that one cycle:
    - wbm_err_o[g]=1 and wbm_ack_o[g]=0;
    - wbs_stb_o is masked to 0;
    - the counter clears.
  - A slave response arriving in the same cycle as the final count wins; no err is generated.
  - Counter width is $clog2(TIMEOUT+1).
- Simultaneous requests: resolved purely by the round-robin pointer.
- Slave response in IDLE: ignored, not forwarded.
- num_masters=1: grant is always master 0 after one IDLE cycle; behaviour is otherwise identical.
- Pipelined handshakes are not supported (classic only). Bursts pass through transparently via cti/bte.

Decomposition:
- Package wb_pkg holds:
  - WB_AW=32, WB_DW=32, WB_SW=4;
  - CTI codes: CLASSIC=3'b000, CONST=3'b001, INCR=3'b010, EOB=3'b111;
  - BTE codes;
  - the arbiter state enum {IDLE, GRANTED}.
- Sub-module wb_rr_picker (combinational): inputs req vector and last index; outputs one-hot grant and the grant index. Instantiated once.
- Muxing and the watchdog stay in wb_arbiter.

Test Plan:
- Reset release, then master 0 issues a single read to 0x00000010 with slave data 0xDEADBEEF:
  - wbs_cyc_o rises 1 cycle after the request;
  - wbm_dat_o/ack reach master 0 only; wbm_ack_o[1]=0.
- Both masters assert cyc in the same cycle:
  - grant order is 0,1,0,1 over four back-to-back transfers;
  - grant_o is 01,10,01,10 with one IDLE cycle between grants.
- Master 1 holds cyc across a 4-beat INCR burst (cti 010,010,010,111) while master 0 requests:
  - master 0 is not granted until 1 cycle after master 1 drops cyc.
- TIMEOUT=8 and the slave never acks:
  - wbm_err_o[g] pulses exactly 1 cycle, 8 cycles after stb;
  - wbs_stb_o is low in that cycle;
  - the master then drops cyc and the arbiter returns to IDLE.
- TIMEOUT=8 and the slave acks on the 8th cycle: ack is forwarded and err stays 0.
- wb_rst_i driven low asynchronously mid-transfer:
  - wbs_cyc_o and all ack/err go 0 without a clock edge;
  - after release, master 0 wins the first contention.
